// File: rtl/add_sub.sv
// rtl/add_sub.sv - binary32 adder/subtractor, RNE, flush-to-zero, 1-cycle registered result.
// Optional flags port {invalid, overflow, underflow, inexact} built when ADDSUB_FLAGS_EN is defined.
module add_sub (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        addsub,
  input  logic        in_valid,
  output logic [31:0] result,
  output logic        out_valid
`ifdef ADDSUB_FLAGS_EN
  ,
  output logic [3:0]  flags
`endif
);

  logic               sa, sb, sl;
  logic [7:0]         ea, eb, el, es, exp_diff;
  logic [22:0]        fa, fb;
  logic               a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  logic [23:0]        sig_l, sig_s;
  logic [52:0]        shift_ext;
  logic [26:0]        big_f, small_f, norm_f;
  logic [27:0]        sum;
  logic [4:0]         lz;
  logic signed [9:0]  exp_n, exp_r;
  logic               round_up;
  logic [24:0]        mant_r;
  logic [22:0]        frac_r;
  logic [31:0]        calc_res;
  logic [3:0]         calc_flags;
  logic [31:0]        result_d, result_q;
  logic               out_valid_d, out_valid_q;

  always_comb begin
    sa = A[31];
    sb = B[31] ^ addsub;
    ea = A[30:23];
    eb = B[30:23];
    fa = A[22:0];
    fb = B[22:0];
    a_zero = (ea == 8'd0);
    b_zero = (eb == 8'd0);
    a_inf  = (ea == 8'hff) && (fa == 23'd0);
    b_inf  = (eb == 8'hff) && (fb == 23'd0);
    a_nan  = (ea == 8'hff) && (fa != 23'd0);
    b_nan  = (eb == 8'hff) && (fb != 23'd0);

    // The larger magnitude fixes sign and exponent, so the subtract never goes negative.
    if ({ea, fa} >= {eb, fb}) begin
      sl = sa;  el = ea;  es = eb;
      sig_l = {1'b1, fa};
      sig_s = {1'b1, fb};
    end else begin
      sl = sb;  el = eb;  es = ea;
      sig_l = {1'b1, fb};
      sig_s = {1'b1, fa};
    end

    exp_diff  = el - es;
    big_f     = {sig_l, 3'b000};
    shift_ext = {sig_s, 3'b000, 26'd0} >> exp_diff;
    if (exp_diff >= 8'd26) small_f = 27'd1;
    else                   small_f = {shift_ext[52:27], shift_ext[26] | (|shift_ext[25:0])};

    lz    = 5'd0;
    exp_n = $signed({2'b00, el});
    if (sa == sb) begin
      sum = {1'b0, big_f} + {1'b0, small_f};
      if (sum[27]) begin
        norm_f = {sum[27:2], sum[1] | sum[0]};
        exp_n  = exp_n + 10'sd1;
      end else begin
        norm_f = sum[26:0];
      end
    end else begin
      sum = {1'b0, big_f} - {1'b0, small_f};
      for (int i = 0; i < 27; i++) begin
        if (sum[i]) lz = 5'(26 - i);
      end
      norm_f = sum[26:0] << lz;
      exp_n  = exp_n - $signed({5'b00000, lz});
    end

    round_up = norm_f[2] & (norm_f[1] | norm_f[0] | norm_f[3]);
    mant_r   = {1'b0, norm_f[26:3]} + {24'd0, round_up};
    exp_r    = mant_r[24] ? exp_n + 10'sd1 : exp_n;
    frac_r   = mant_r[24] ? mant_r[23:1] : mant_r[22:0];

    calc_flags = 4'b0000;
    if (a_nan || b_nan) begin
      calc_res = 32'h7fc00000;
    end else if (a_inf && b_inf && (sa != sb)) begin
      calc_res   = 32'h7fc00000;
      calc_flags = 4'b1000;
    end else if (a_inf) begin
      calc_res = {sa, 8'hff, 23'd0};
    end else if (b_inf) begin
      calc_res = {sb, 8'hff, 23'd0};
    end else if (a_zero && b_zero) begin
      calc_res = {sa & sb, 31'd0};
    end else if (a_zero) begin
      calc_res = {sb, B[30:0]};
    end else if (b_zero) begin
      calc_res = A;
    end else if ((sa != sb) && (sum == 28'd0)) begin
      calc_res = 32'h00000000;
    end else if (exp_n <= 10'sd0) begin
      calc_res   = {sl, 31'd0};
      calc_flags = {2'b00, 1'b1, |norm_f[2:0]};
    end else if (exp_r >= 10'sd255) begin
      calc_res   = {sl, 8'hff, 23'd0};
      calc_flags = 4'b0101;
    end else begin
      calc_res   = {sl, exp_r[7:0], frac_r};
      calc_flags = {3'b000, |norm_f[2:0]};
    end

    result_d    = in_valid ? calc_res : result_q;
    out_valid_d = in_valid;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      result_q    <= 32'h00000000;
      out_valid_q <= 1'b0;
    end else begin
      result_q    <= result_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign result    = result_q;
  assign out_valid = out_valid_q;

`ifdef ADDSUB_FLAGS_EN
  logic [3:0] flags_d, flags_q;

  always_comb begin
    flags_d = in_valid ? calc_flags : flags_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) flags_q <= 4'b0000;
    else        flags_q <= flags_d;
  end

  assign flags = flags_q;
`else
  logic unused_flags;
  assign unused_flags = ^calc_flags;
`endif

endmodule

// File: tb/tb_add_sub.sv
// tb/tb_add_sub.sv - scoreboard bench for add_sub against an exact-integer binary32 model.
module tb_add_sub;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] a_in, b_in;
  logic        op_in;
  logic        in_valid;
  logic [31:0] result;
  logic        out_valid;
`ifdef ADDSUB_FLAGS_EN
  logic [3:0]  flags;
`endif

  add_sub dut (
    .clk(clk), .rst_n(rst_n), .A(a_in), .B(b_in), .addsub(op_in),
    .in_valid(in_valid), .result(result), .out_valid(out_valid)
`ifdef ADDSUB_FLAGS_EN
    , .flags(flags)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic [3:0]  flg;
    int          due;
  } exp_t;

  exp_t        q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          cycle    = 0;
  logic [31:0] last_res = 32'h0;

  // Operands become integers in units of 2^-149, so the sum is exact before rounding.
  function automatic logic [35:0] ref_model(input logic [31:0] a, input logic [31:0] b, input logic op);
    logic sa, sb, s, up, inx;
    int ea, eb, p, er, sh;
    logic [299:0] va, vb, mag, kept, rem, half;
    sa = a[31];
    sb = b[31] ^ op;
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    if ((ea == 255 && a[22:0] != 0) || (eb == 255 && b[22:0] != 0)) return {32'h7fc00000, 4'b0000};
    if (ea == 255 && eb == 255 && sa != sb) return {32'h7fc00000, 4'b1000};
    if (ea == 255) return {sa, 8'hff, 23'd0, 4'b0000};
    if (eb == 255) return {sb, 8'hff, 23'd0, 4'b0000};
    if (ea == 0 && eb == 0) return {sa & sb, 31'd0, 4'b0000};
    if (ea == 0) return {sb, b[30:0], 4'b0000};
    if (eb == 0) return {a, 4'b0000};
    va = 300'({1'b1, a[22:0]}) << (ea - 1);
    vb = 300'({1'b1, b[22:0]}) << (eb - 1);
    if (sa == sb)      begin mag = va + vb; s = sa; end
    else if (va >= vb) begin mag = va - vb; s = sa; end
    else               begin mag = vb - va; s = sb; end
    if (mag == 0) return 36'h0;
    p = 0;
    for (int i = 0; i < 300; i++) if (mag[i]) p = i;
    er = p - 22;
    if (er <= 0) return {s, 31'd0, 4'b0010};
    sh   = p - 23;
    kept = mag >> sh;
    rem  = mag & ((300'd1 << sh) - 300'd1);
    inx  = (rem != 0);
    up   = 1'b0;
    if (sh > 0) begin
      half = 300'd1 << (sh - 1);
      up   = (rem > half) || (rem == half && kept[0]);
    end
    kept = kept + 300'(up);
    if (kept[24]) begin
      kept = kept >> 1;
      er   = er + 1;
    end
    if (er >= 255) return {s, 8'hff, 23'd0, 4'b0101};
    return {s, er[7:0], kept[22:0], 3'b000, inx};
  endfunction

  function automatic logic [31:0] rand_op(input logic [31:0] other);
    int k;
    logic [31:0] v;
    k = $urandom_range(0, 15);
    v = $urandom;
    case (k)
      0: begin
        case ($urandom_range(0, 6))
          0: v = 32'h00000000;
          1: v = 32'h80000000;
          2: v = 32'h7f800000;
          3: v = 32'hff800000;
          4: v = 32'h7fc00001;
          5: v = 32'h00000123;
          default: v = 32'h7f7fffff;
        endcase
      end
      1, 2, 3, 4, 5: v[30:23] = other[30:23] + 8'($urandom_range(0, 4)) - 8'd2;
      6: v[30:0] = other[30:0];
      7: begin
        v[30:23] = other[30:23];
        v[22:0]  = other[22:0] ^ 23'($urandom_range(0, 3));
      end
      default: ;
    endcase
    return v;
  endfunction

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic op,
                       input logic [31:0] er, input logic [3:0] ef);
    @(negedge clk);
    a_in = a;
    b_in = b;
    op_in = op;
    in_valid = 1'b1;
    q.push_back('{er, ef, cycle + 1});
    last_res = er;
  endtask

  task automatic issue_rand();
    logic [31:0] a, b;
    logic op;
    logic [35:0] m;
    a  = $urandom;
    b  = rand_op(a);
    if ($urandom_range(0, 1) == 1) a = rand_op(b);
    op = 1'($urandom_range(0, 1));
    m  = ref_model(a, b, op);
    issue(a, b, op, m[35:4], m[3:0]);
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
    a_in = $urandom;
    b_in = $urandom;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  always @(posedge clk) begin
    cycle = cycle + 1;
    #1;
    if (out_valid === 1'b1) begin
      if (q.size() == 0) begin
        check("unexpected_out_valid", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("latency_cycle", cycle, e.due);
        check("result", result, e.res);
`ifdef ADDSUB_FLAGS_EN
        check("flags", {28'd0, flags}, {28'd0, e.flg});
`endif
      end
    end else if (q.size() != 0 && q[0].due <= cycle) begin
      check("missing_out_valid", {31'd0, out_valid}, 32'd1);
      void'(q.pop_front());
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    a_in = 32'h0;
    b_in = 32'h0;
    op_in = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_result", result, 32'h00000000);
    check("reset_out_valid", {31'd0, out_valid}, 32'd0);
`ifdef ADDSUB_FLAGS_EN
    check("reset_flags", {28'd0, flags}, 32'd0);
`endif
    rst_n = 1'b1;

    issue(32'h3f800000, 32'h3f000000, 1'b0, 32'h3fc00000, 4'b0000);
    issue(32'h3f800000, 32'hbfc00000, 1'b0, 32'hbf000000, 4'b0000);
    issue(32'h3f800000, 32'hbfc00000, 1'b1, 32'h40200000, 4'b0000);
    issue(32'h3f800000, 32'h3f000000, 1'b1, 32'h3f000000, 4'b0000);
    issue(32'h3f800000, 32'h3f800000, 1'b1, 32'h00000000, 4'b0000);
    issue(32'h3f800000, 32'h33800000, 1'b0, 32'h3f800000, 4'b0001);
    issue(32'h3f800001, 32'h33800000, 1'b0, 32'h3f800002, 4'b0001);
    issue(32'h7f800000, 32'h7f800000, 1'b1, 32'h7fc00000, 4'b1000);
    issue(32'h7f7fffff, 32'h7f7fffff, 1'b0, 32'h7f800000, 4'b0101);
    issue(32'h7fc00000, 32'h3f800000, 1'b0, 32'h7fc00000, 4'b0000);
    issue(32'h3f800000, 32'hffc00001, 1'b1, 32'h7fc00000, 4'b0000);
    issue(32'h80000000, 32'h00000000, 1'b1, 32'h80000000, 4'b0000);
    issue(32'h00000000, 32'h40490fdb, 1'b1, 32'hc0490fdb, 4'b0000);
    issue(32'h00800001, 32'h00800000, 1'b1, 32'h00000000, 4'b0010);

    idle();
    @(posedge clk);
    #2;
    check("hold_out_valid", {31'd0, out_valid}, 32'd0);
    check("hold_result", result, last_res);

    @(negedge clk);
    rst_n = 1'b0;
    in_valid = 1'b1;
    a_in = 32'h3f800000;
    b_in = 32'h3f800000;
    op_in = 1'b0;
    @(posedge clk);
    #2;
    check("reset_inflight_result", result, 32'h00000000);
    check("reset_inflight_out_valid", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b0;
    last_res = 32'h0;

    repeat (8) issue_rand();
    idle();

    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 5) == 0) idle();
      else issue_rand();
    end
    idle();

    for (int w = 0; w < 10 && q.size() != 0; w++) @(negedge clk);
    check("scoreboard_drained", q.size(), 32'd0);
    @(posedge clk);
    #2;
    check("final_hold_result", result, last_res);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
